// File: rtl/cgra_load_sequencer.sv
// Host-side command sequencer for the CGRA core.
// Each accepted command streams cmd_len_in words from a valid/ready stream into one
// of four core write ports at consecutive addresses. It can then pulse core start,
// wait for the completion level and report done.
// Optional build macro: CGRA_SEQ_TIMEOUT_EN bounds the WAIT state to TIMEOUT_CYCLES
// cycles and reports expiry on err_out. When the macro is undefined, err_out is tied low.
module cgra_load_sequencer #(
  parameter int unsigned ADDR_W         = 16,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned LEN_W          = 12,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              cmd_valid_in,
  output logic              cmd_ready_out,
  input  logic [1:0]        cmd_target_in,
  input  logic [ADDR_W-1:0] cmd_base_in,
  input  logic [LEN_W-1:0]  cmd_len_in,
  input  logic              cmd_run_in,
  input  logic              s_valid_in,
  input  logic [DATA_W-1:0] s_data_in,
  output logic              s_ready_out,
  output logic [3:0]        wr_en_out,
  output logic [ADDR_W-1:0] wr_addr_out,
  output logic [DATA_W-1:0] wr_data_out,
  output logic              core_start_out,
  input  logic              core_complete_in,
  output logic              busy_out,
  output logic              done_out,
  output logic              err_out
);

  // Wide enough to hold TIMEOUT_CYCLES-1. In the default build, the counter stops at 2.
  localparam int unsigned WaitW = (TIMEOUT_CYCLES > 4) ? $clog2(TIMEOUT_CYCLES) : 2;

  typedef enum logic [2:0] {StIdle, StLoad, StStart, StWait, StDone} state_e;

  state_e            state_q;
  logic [1:0]        tgt_q;
  logic [ADDR_W-1:0] base_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  cnt_q;
  logic              run_q;
  logic [WaitW-1:0]  wait_cnt_q;

  logic load_hs;
  logic last_word;
  logic wait_open;

  assign load_hs   = (state_q == StLoad) && s_valid_in;
  assign last_word = (cnt_q == len_q - LEN_W'(1));
  // core_complete_in is still stale from the previous run for the first two WAIT cycles.
  assign wait_open = (wait_cnt_q >= WaitW'(2));

`ifdef CGRA_SEQ_TIMEOUT_EN
  logic err_q;
  assign err_out = err_q;
`else
  assign err_out = 1'b0;
`endif

  // Command FSM: latches the command, counts words and paces start/wait/done.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= StIdle;
      tgt_q      <= 2'd0;
      base_q     <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      run_q      <= 1'b0;
      wait_cnt_q <= '0;
`ifdef CGRA_SEQ_TIMEOUT_EN
      err_q      <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (cmd_valid_in) begin
            tgt_q  <= cmd_target_in;
            base_q <= cmd_base_in;
            len_q  <= cmd_len_in;
            run_q  <= cmd_run_in;
            cnt_q  <= '0;
`ifdef CGRA_SEQ_TIMEOUT_EN
            err_q  <= 1'b0;
`endif
            if (cmd_len_in != '0) begin
              state_q <= StLoad;
            end else if (cmd_run_in) begin
              state_q <= StStart;
            end else begin
              state_q <= StDone;
            end
          end
        end
        StLoad: begin
          if (s_valid_in) begin
            cnt_q <= cnt_q + LEN_W'(1);
            if (last_word) begin
              state_q <= run_q ? StStart : StDone;
            end
          end
        end
        StStart: begin
          wait_cnt_q <= '0;
          state_q    <= StWait;
        end
        StWait: begin
          if (wait_open && core_complete_in) begin
            state_q <= StDone;
`ifdef CGRA_SEQ_TIMEOUT_EN
          end else if (wait_cnt_q == WaitW'(TIMEOUT_CYCLES - 1)) begin
            state_q <= StDone;
            err_q   <= 1'b1;
          end else begin
            wait_cnt_q <= wait_cnt_q + WaitW'(1);
          end
`else
          end else if (!wait_open) begin
            wait_cnt_q <= wait_cnt_q + WaitW'(1);
          end
`endif
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Outputs are decoded from state, and the write port passes the stream word straight through on a handshake.
  always_comb begin
    cmd_ready_out  = (state_q == StIdle);
    s_ready_out    = (state_q == StLoad);
    core_start_out = (state_q == StStart);
    busy_out       = (state_q != StIdle);
    done_out       = (state_q == StDone);
    wr_en_out      = 4'b0000;
    wr_addr_out    = '0;
    wr_data_out    = '0;
    if (load_hs) begin
      wr_en_out[tgt_q] = 1'b1;
      wr_addr_out      = base_q + ADDR_W'(cnt_q);
      wr_data_out      = s_data_in;
    end
  end

endmodule

// File: tb/tb_cgra_load_sequencer.sv
// Self-checking bench for cgra_load_sequencer. A timeline model predicts, for each cycle of a
// command, which word is written, when start and done appear, and the
// busy, ready and err levels.
module tb_cgra_load_sequencer;

  localparam int MAXC = 256;
`ifdef CGRA_SEQ_TIMEOUT_EN
  localparam int TMO = 20;
`else
  localparam int TMO = 0;
`endif

  logic        CLK = 1'b0;
  logic        RST;
  logic        cmd_valid_in;
  logic        cmd_ready_out;
  logic [1:0]  cmd_target_in;
  logic [15:0] cmd_base_in;
  logic [11:0] cmd_len_in;
  logic        cmd_run_in;
  logic        s_valid_in;
  logic [31:0] s_data_in;
  logic        s_ready_out;
  logic [3:0]  wr_en_out;
  logic [15:0] wr_addr_out;
  logic [31:0] wr_data_out;
  logic        core_start_out;
  logic        core_complete_in;
  logic        busy_out;
  logic        done_out;
  logic        err_out;

  int   total = 0;
  int   bad = 0;
  logic prev_err = 1'b0;

  cgra_load_sequencer #(
    .ADDR_W(16),
    .DATA_W(32),
    .LEN_W(12),
    .TIMEOUT_CYCLES(20)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .cmd_valid_in(cmd_valid_in),
    .cmd_ready_out(cmd_ready_out),
    .cmd_target_in(cmd_target_in),
    .cmd_base_in(cmd_base_in),
    .cmd_len_in(cmd_len_in),
    .cmd_run_in(cmd_run_in),
    .s_valid_in(s_valid_in),
    .s_data_in(s_data_in),
    .s_ready_out(s_ready_out),
    .wr_en_out(wr_en_out),
    .wr_addr_out(wr_addr_out),
    .wr_data_out(wr_data_out),
    .core_start_out(core_start_out),
    .core_complete_in(core_complete_in),
    .busy_out(busy_out),
    .done_out(done_out),
    .err_out(err_out)
  );

  always #5 CLK = ~CLK;

  // Core model: complete is stale-high until 2 cycles after start. It re-rises 'rise' cycles later
  // (a value of 0 means never).
  function automatic logic comp_at(input int cyc, input int ts, input int rise);
    return (cyc < ts + 2) || ((rise > 0) && (cyc >= ts + 2 + rise));
  endfunction

  // Cycle 0 is the accept cycle. The bench checks writes and control levels on every cycle until
  // done + 2.
  task automatic run_cmd(input string name, input logic [1:0] tgt, input logic [15:0] base,
                         input int len, input bit run, input int gap, input logic [31:0] dseed,
                         input int rise, input bit spur);
    int          wr_at[MAXC];
    bit          vld[MAXC];
    logic [31:0] data[64];
    int          t, j, i, t_last, ts, td;
    bit          v, tmo, in_load, exp_busy;
    logic [3:0]  exp_we;
    logic [15:0] exp_addr;
    logic [31:0] exp_data;
    logic        exp_err;
    logic [5:0]  exp_ctrl, act_ctrl;
    for (int c = 0; c < MAXC; c++) begin
      wr_at[c] = -1;
      vld[c]   = 1'($urandom_range(0, 1));
    end
    for (int k = 0; k < len; k++) data[k] = (dseed != 0) ? dseed + 32'(k) : $urandom;
    t = 1;
    j = 0;
    while (j < len) begin
      if (gap == 0) v = 1'b1;
      else if (gap == 1) v = ((t - 1) % 2 == 0);
      else v = ($urandom_range(0, 2) != 0);
      vld[t] = v;
      if (v) begin
        wr_at[t] = j;
        j++;
      end
      t++;
    end
    t_last = (len > 0) ? t - 1 : 0;
    tmo = 1'b0;
    ts = -1;
    td = -1;
    if (run) begin
      ts = t_last + 1;
      i = 0;
      while (td < 0) begin
        if (i >= 2 && comp_at(ts + 1 + i, ts, rise)) begin
          td = ts + 2 + i;
        end else if (TMO > 0 && i == TMO - 1) begin
          td = ts + 1 + TMO;
          tmo = 1'b1;
        end else if (i > MAXC) begin
          td = MAXC;
        end
        i++;
      end
    end else begin
      td = t_last + 1;
    end
    if (td + 3 >= MAXC) begin
      $display("FAIL %s setup: got timeline %0d cycles, want < %0d", name, td + 3, MAXC);
      $fatal(1);
    end
    for (int c = 0; c <= td + 2; c++) begin
      if (c == 0) begin
        cmd_valid_in  = 1'b1;
        cmd_target_in = tgt;
        cmd_base_in   = base;
        cmd_len_in    = 12'(len);
        cmd_run_in    = run;
      end else begin
        cmd_valid_in  = spur && run && (c > ts) && (c <= td);
        cmd_target_in = 2'($urandom);
        cmd_base_in   = 16'($urandom);
        cmd_len_in    = 12'($urandom_range(1, 5));
        cmd_run_in    = 1'($urandom);
      end
      s_valid_in       = vld[c];
      s_data_in        = (wr_at[c] >= 0) ? data[wr_at[c]] : $urandom;
      core_complete_in = run ? comp_at(c, ts, rise) : 1'b1;
      @(negedge CLK);
      in_load  = (len > 0) && (c >= 1) && (c <= t_last);
      exp_busy = (c >= 1) && (c <= td);
      exp_we   = (wr_at[c] >= 0) ? (4'b0001 << tgt) : 4'b0000;
      exp_addr = (wr_at[c] >= 0) ? 16'(base + 16'(wr_at[c])) : 16'h0000;
      exp_data = (wr_at[c] >= 0) ? data[wr_at[c]] : 32'h0;
      exp_err  = (c == 0) ? prev_err : ((c >= td) ? tmo : 1'b0);
      exp_ctrl = {!exp_busy, in_load, run && (c == ts), exp_busy, c == td, exp_err};
      act_ctrl = {cmd_ready_out, s_ready_out, core_start_out, busy_out, done_out, err_out};
      total++;
      if ({wr_en_out, wr_addr_out, wr_data_out} !== {exp_we, exp_addr, exp_data}) begin
        bad++;
        $display("FAIL %s write c=%0d: got en=%b addr=%h data=%h, want en=%b addr=%h data=%h",
                 name, c, wr_en_out, wr_addr_out, wr_data_out, exp_we, exp_addr, exp_data);
      end
      total++;
      if (act_ctrl !== exp_ctrl) begin
        bad++;
        $display("FAIL %s ctrl c=%0d: got rdy/srdy/start/busy/done/err=%b, want %b",
                 name, c, act_ctrl, exp_ctrl);
      end
      @(posedge CLK);
      #1;
    end
    cmd_valid_in = 1'b0;
    s_valid_in   = 1'b0;
    prev_err     = tmo;
  endtask

  task automatic test_reset();
    #1;
    total++;
    if ({cmd_ready_out, s_ready_out, core_start_out, busy_out, done_out, err_out, wr_en_out}
        !== 10'b1_0_0_0_0_0_0000) begin
      bad++;
      $display("FAIL reset_state: got rdy=%b srdy=%b start=%b busy=%b done=%b err=%b we=%b, want 1 0 0 0 0 0 0000",
               cmd_ready_out, s_ready_out, core_start_out, busy_out, done_out, err_out, wr_en_out);
    end
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset_mid_load();
    cmd_valid_in  = 1'b1;
    cmd_target_in = 2'd2;
    cmd_base_in   = 16'h0200;
    cmd_len_in    = 12'd8;
    cmd_run_in    = 1'b0;
    @(posedge CLK);
    #1;
    cmd_valid_in = 1'b0;
    s_valid_in   = 1'b1;
    for (int w = 1; w <= 3; w++) begin
      s_data_in = $urandom;
      @(negedge CLK);
      if (w < 3) begin
        @(posedge CLK);
        #1;
      end
    end
    total++;
    if ({wr_en_out, wr_addr_out} !== {4'b0100, 16'h0202}) begin
      bad++;
      $display("FAIL mid_load_word3: got en=%b addr=%h, want en=0100 addr=0202",
               wr_en_out, wr_addr_out);
    end
    #2 RST = 1'b0;
    #1;
    total++;
    if ({wr_en_out, core_start_out, s_ready_out, busy_out, cmd_ready_out} !== 8'b0000_0_0_0_1) begin
      bad++;
      $display("FAIL async_reset: got en=%b start=%b srdy=%b busy=%b rdy=%b, want 0000 0 0 0 1",
               wr_en_out, core_start_out, s_ready_out, busy_out, cmd_ready_out);
    end
    @(posedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge CLK);
      #1;
      @(negedge CLK);
      total++;
      if ({cmd_ready_out, busy_out, done_out, core_start_out, wr_en_out} !== 8'b1_0_0_0_0000) begin
        bad++;
        $display("FAIL post_reset k=%0d: got rdy=%b busy=%b done=%b start=%b en=%b, want 1 0 0 0 0000",
                 k, cmd_ready_out, busy_out, done_out, core_start_out, wr_en_out);
      end
    end
    s_valid_in = 1'b0;
    prev_err   = 1'b0;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_load_b2b();
    run_cmd("load_b2b", 2'd1, 16'h0040, 4, 1'b0, 0, 32'hA0, 0, 1'b0);
  endtask

  task automatic test_load_gaps();
    run_cmd("load_gaps", 2'd1, 16'h0040, 4, 1'b0, 1, 32'hA0, 0, 1'b0);
  endtask

  task automatic test_wrap_run();
    run_cmd("wrap_run", 2'd3, 16'hFFFE, 3, 1'b1, 0, 32'h0, 10, 1'b0);
  endtask

  task automatic test_len0_run();
    run_cmd("len0_run", 2'd0, 16'h1234, 0, 1'b1, 0, 32'h0, 5, 1'b1);
  endtask

  task automatic test_timeout();
`ifdef CGRA_SEQ_TIMEOUT_EN
    run_cmd("timeout", 2'd2, 16'h0100, 2, 1'b1, 2, 32'h0, 0, 1'b0);
    run_cmd("err_clear", 2'd0, 16'h0010, 1, 1'b0, 0, 32'h55, 0, 1'b0);
`else
    run_cmd("long_wait", 2'd2, 16'h0100, 2, 1'b1, 2, 32'h0, 40, 1'b0);
`endif
  endtask

  task automatic test_random();
    for (int n = 0; n < 12; n++) begin
      run_cmd("random", 2'($urandom_range(0, 3)), 16'($urandom), int'($urandom_range(0, 6)),
              1'($urandom_range(0, 1)), int'($urandom_range(0, 2)), 32'h0,
              int'($urandom_range(1, 8)), 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    RST              = 1'b0;
    cmd_valid_in     = 1'b0;
    cmd_target_in    = 2'd0;
    cmd_base_in      = 16'h0;
    cmd_len_in       = 12'h0;
    cmd_run_in       = 1'b0;
    s_valid_in       = 1'b0;
    s_data_in        = 32'h0;
    core_complete_in = 1'b1;
    test_reset();
    test_reset_mid_load();
    test_load_b2b();
    test_load_gaps();
    test_wrap_run();
    test_len0_run();
    test_timeout();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cgra_load_sequencer.md
Name: cgra_load_sequencer

Overview:
Host-side command sequencer in front of the CGRA core. It accepts one command at a time. Each command streams N words from a valid/ready data stream into one of the core's write ports (RC context, PE context, IM context or LDM) at consecutive addresses. It can then pulse the core's start, wait for its completion level and report done. It serialises all host loading and kick-off, so software issues commands rather than driving individual memory-port strobes.

Parameters:
ADDR_W, 16, target word address width (upper bits carry PE/row index as the target port expects)
DATA_W, 32, stream/write data width
LEN_W, 12, width of the command word count
TIMEOUT_CYCLES, 65535, WAIT-state limit (used only when the optional feature is compiled in)

Ports:
CLK  in  1  clock
RST  in  1  reset, asynchronous, active-low
cmd_valid_in  in  1  command offered
cmd_ready_out  out  1  command accepted when high with cmd_valid_in
cmd_target_in  in  2  0=CTX_RC, 1=CTX_PE, 2=CTX_IM, 3=LDM
cmd_base_in  in  ADDR_W  first write address
cmd_len_in  in  LEN_W  words to load; 0 = no load
cmd_run_in  in  1  after load, start core and wait for completion
s_valid_in  in  1  stream word valid
s_data_in  in  DATA_W  stream word
s_ready_out  out  1  stream ready
wr_en_out  out  4  one-hot write strobe per target (drives ena and wea together)
wr_addr_out  out  ADDR_W  write address
wr_data_out  out  DATA_W  write data
core_start_out  out  1  one-cycle start pulse to core
core_complete_in  in  1  core completion level (stays high until the next start)
busy_out  out  1  state != IDLE
done_out  out  1  one-cycle pulse at command end
err_out  out  1  set with done_out if the command timed out; held until the next accepted command

Behaviour:
- Reset: state IDLE; count, latched command and guard counter cleared; all outputs 0 except cmd_ready_out=1. Reset mid-command abandons it immediately. wr_en_out and core_start_out drop asynchronously. No done_out is issued.
- States: IDLE, LOAD, START, WAIT, DONE.
- IDLE:
  - cmd_ready_out=1.
  - On cmd_valid_in, latch target, base, len and run, and clear err_out.
  - Next state is LOAD if len!=0; else START if run=1; else DONE.
- LOAD:
  - s_ready_out=1.
  - Write is combinational on handshake: wr_en_out[target]=s_valid_in, wr_addr_out=base+count (mod 2^ADDR_W, wraps silently), wr_data_out=s_data_in.
  - count increments per handshake.
  - On the handshake with count==len-1, next state is START if run=1, else DONE.
  - Stream gaps (s_valid_in low) stall without limit.
- START: core_start_out=1 for exactly one cycle, then WAIT. This is always the cycle after the last write, so the final word is committed before the core launches.
- WAIT:
  - core_complete_in is stale high from the previous run and is cleared by the core only two cycles after the start pulse.
  - The sequencer therefore ignores core_complete_in for the first 2 WAIT cycles and samples it from the 3rd WAIT cycle on.
  - When high, next state is DONE.
- DONE: done_out=1 for one cycle, then IDLE.
- Outside IDLE: cmd_ready_out=0 and cmd_valid_in is ignored.
- Outside LOAD: s_ready_out=0, s_valid_in is ignored and wr_en_out=0.
- wr_addr_out and wr_data_out are don't-care when wr_en_out=0. Implementation drives them 0.
- Latency:
  - cmd accept to first possible write: 1 cycle.
  - Last write to core_start_out: 1 cycle.
  - Complete sampled high to done_out: 1 cycle.

Optional Feature:
Macro CGRA_SEQ_TIMEOUT_EN.
- Defined: a cycle counter runs in WAIT. If it reaches TIMEOUT_CYCLES without a sampled complete, the state moves to DONE, err_out is set and done_out pulses.
- Not defined: no counter; WAIT lasts until complete and err_out is tied 0.

Test Plan:
1. Reset with RST=0 mid-LOAD (word 3 of 8) -> all strobes 0 at once; after release cmd_ready_out=1, busy_out=0, no done_out.
2. cmd target=1, base=0x0040, len=4, run=0, stream 0xA0..0xA3 back-to-back -> wr_en_out=4'b0010 on 4 consecutive cycles at addresses 0x40..0x43 with matching data; done_out 1 cycle after the 4th write; no core_start_out.
3. Same as 2 with s_valid_in low every other cycle -> exactly 4 writes, addresses contiguous, no write during gaps.
4. cmd target=3, base=0xFFFE, len=3, run=1; core_complete_in held high throughout and dropped 2 cycles after start, re-raised 10 cycles later -> writes at 0xFFFE, 0xFFFF, 0x0000; start 1 cycle after the last write; stale complete ignored; done_out 1 cycle after re-raise.
5. len=0, run=1 -> IDLE to START directly, no wr_en_out; cmd_valid_in asserted during WAIT is not accepted (cmd_ready_out=0).
6. With CGRA_SEQ_TIMEOUT_EN and TIMEOUT_CYCLES=20, complete never re-asserts -> done_out and err_out=1 after 20 WAIT cycles; err_out clears when the next command is accepted.
